int_seq_ctrl: RTL and testbench
===============================

Name: int_seq_ctrl

Overview:
- Multi-source nested interrupt sequencer for the fetch stage.
- Latches interrupt requests, arbitrates by fixed priority against the in-service set, and drives one-cycle `interrupt`/`eret` redirect pulses plus `int_pc` (vector or restored EPC) to the IF next-PC mux.
- Keeps an internal EPC/priority stack so higher-priority sources preempt lower ones and `eret` unwinds in order.

Parameters:
- NUM_SRC, 3: number of interrupt sources; index 0 is highest priority.
- VEC_BASE, 32'h0000_0200: handler address of source 0.
- VEC_STRIDE, 32'h0000_0010: address step between successive source vectors.

Ports:
- clk  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- irq_req  input  NUM_SRC  raw request lines.
- int_en  input  1  global interrupt enable.
- stall  input  1  pipeline stall; freezes the sequencer.
- eret_req  input  1  decoded ERET instruction, 1-cycle.
- epc_in  input  32  address the pipeline would fetch next; saved on entry.
- interrupt  output  1  1-cycle redirect-to-vector pulse.
- eret  output  1  1-cycle redirect-to-EPC pulse.
- int_pc  output  32  redirect target, valid while interrupt or eret is high.
- in_service  output  NUM_SRC  sources currently being handled.
- depth  output  $clog2(NUM_SRC+1)  nesting depth.
- stack_err  output  1  sticky flag: eret_req received with depth==0.

Behaviour:
- Reset (RST=1 at a clk edge):
  - pending, in_service, depth, stack_err, interrupt and eret all go to 0.
  - int_pc goes to 32'h0. State goes to S_IDLE.
  - Reset mid-sequence aborts it; no pulse is emitted afterwards.
- Pending: see INTC_IRQ_EDGE_EN.
  - A pending bit clears only when its source is accepted.
  - Set and clear in the same cycle: set wins.
- Eligible source: the lowest index i with pending[i]=1 and int_en=1, and i strictly lower than the lowest set bit of in_service (any i if in_service==0).
- States:
  - S_IDLE, stall=0, eret_req=1, depth>0:
    - Pop the stack. Clear the in_service bit of the popped source.
    - Load int_pc with the popped EPC. Go to S_RET.
  - S_IDLE, stall=0, eret_req=1, depth==0: set stack_err; no pulse; stay in S_IDLE.
  - S_IDLE, stall=0, eret_req=0, an eligible source i exists:
    - Record i. Clear pending[i].
    - Load int_pc = VEC_BASE + i*VEC_STRIDE (32-bit, wrap-around ignored). Go to S_ENT.
  - S_ENT:
    - interrupt=1 for this cycle.
    - Push {epc_in, i} onto the stack; depth+1; set in_service[i]. Return to S_IDLE.
  - S_RET: eret=1 for this cycle; return to S_IDLE.
- Latency:
  - Request pending at edge N → interrupt high in cycle N+2 (decision cycle N+1).
  - eret_req in cycle N → eret high in cycle N+1.
- eret_req and an eligible source in the same cycle: eret wins; the source stays pending and is re-arbitrated in the next S_IDLE cycle.
- stall=1:
  - In S_IDLE, no decision is made; pending still accumulates.
  - In S_ENT or S_RET, the state, pulse and int_pc hold until stall=0, so the pulse lasts until the first unstalled cycle.
  - The push/pop completes on that unstalled cycle.
  - epc_in is sampled on that same cycle.
- Stack depth is NUM_SRC. Overflow is impossible because preemption needs strictly higher priority; pushing while full is an assertion failure.
- int_en=0 blocks new entries only; eret still functions.
- int_pc holds its last value when neither pulse is active.

Optional Feature:
- Macro INTC_IRQ_EDGE_EN.
- Defined:
  - irq_req is registered.
  - pending[i] is set on a 0→1 transition of irq_req[i].
  - A held-high line produces exactly one entry.
- Undefined:
  - pending[i] is set every cycle irq_req[i]=1 (level-sensitive).
  - The source re-enters after eret if still asserted.

Test Plan (NUM_SRC=3, VEC_BASE=0x200, VEC_STRIDE=0x10):
- Single entry and return:
  - Stimulus: irq_req=3'b010 pulse, int_en=1, epc_in=0x40, then eret_req.
  - Response: interrupt 1 cycle with int_pc=0x210, in_service=010, depth=1.
  - Then eret 1 cycle with int_pc=0x40, in_service=000.
- Nested preemption:
  - Stimulus: source 2 entered with epc 0x40; then source 0 with epc_in=0x224; then two erets.
  - Response: source 2 at int_pc=0x220; source 0 at int_pc=0x200; depth=2.
  - erets return 0x224, then 0x40.
- No preemption:
  - Stimulus: source 1 in service; source 2 requested.
  - Response: no interrupt until after eret, then int_pc=0x220.
- Simultaneous eret_req and irq_req[0]:
  - Response: eret first; interrupt to 0x200 exactly 2 cycles later.
- Stall during S_ENT for 3 cycles:
  - Response: interrupt held 4 cycles; int_pc=0x200 stable; single push, depth=1.
- eret_req at depth 0:
  - Response: stack_err=1, no eret pulse.
- Reset asserted in S_ENT:
  - Response: all outputs 0, depth=0, no later pulse.

Source files
------------

// File: rtl/int_seq_ctrl.sv
`default_nettype none
// ============================================================================
// int_seq_ctrl : nested fixed-priority interrupt sequencer for the IF next-PC mux
// Option macro INTC_IRQ_EDGE_EN: edge-triggered request capture (default level)
// Rev 1.0
// ============================================================================
module int_seq_ctrl #(
    parameter int          NUM_SRC    = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0200,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic [NUM_SRC-1:0]           irq_req,
    input  logic                         int_en,
    input  logic                         stall,
    input  logic                         eret_req,
    input  logic [31:0]                  epc_in,
    output logic                         interrupt,
    output logic                         eret,
    output logic [31:0]                  int_pc,
    output logic [NUM_SRC-1:0]           in_service,
    output logic [$clog2(NUM_SRC+1)-1:0] depth,
    output logic                         stack_err
);

    localparam int                 c_DW  = $clog2(NUM_SRC + 1);
    localparam int                 c_SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [NUM_SRC-1:0] c_ONE = NUM_SRC'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENT  = 2'd1,
        S_RET  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_in_service;
    logic [c_DW-1:0]    r_depth;
    logic               r_stack_err;
    logic [31:0]        r_int_pc;
    logic [c_SW-1:0]    r_sel;

    logic [31:0]        r_stk_epc [NUM_SRC];
    logic [c_SW-1:0]    r_stk_src [NUM_SRC];

    logic [NUM_SRC-1:0] w_set;
    logic               w_found;
    logic [c_SW-1:0]    w_sel;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_err;
    logic [c_DW-1:0]    w_top;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pop_clr;
    logic [NUM_SRC-1:0] w_push_set;

`ifdef INTC_IRQ_EDGE_EN
    logic [NUM_SRC-1:0] r_irq_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_irq_q <= '0;
        end else begin
            r_irq_q <= irq_req;
        end
    end

    assign w_set = irq_req & ~r_irq_q;
`else
    assign w_set = irq_req;
`endif

    // A source is eligible only if every in-service source has a larger index.
    always_comb begin
        logic w_blocked;
        w_blocked = 1'b0;
        w_found   = 1'b0;
        w_sel     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_in_service[i]) begin
                w_blocked = 1'b1;
            end
            if (!w_blocked && !w_found && r_pending[i] && int_en) begin
                w_found = 1'b1;
                w_sel   = c_SW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!stall) begin
                    if (eret_req) begin
                        if (r_depth != '0) begin
                            w_pop       = 1'b1;
                            w_state_nxt = S_RET;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if (w_found) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_ENT;
                    end
                end
            end
            S_ENT: begin
                if (!stall) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RET: begin
                if (!stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_top      = r_depth - 1'b1;
    assign w_clr      = w_accept ? (c_ONE << w_sel) : '0;
    assign w_pop_clr  = w_pop ? (c_ONE << r_stk_src[w_top]) : '0;
    assign w_push_set = w_push ? (c_ONE << r_sel) : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_in_service <= '0;
            r_depth      <= '0;
            r_stack_err  <= 1'b0;
            r_int_pc     <= 32'h0;
            r_sel        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            // New requests override the acceptance clear in the same cycle.
            r_pending    <= (r_pending & ~w_clr) | w_set;
            r_in_service <= (r_in_service & ~w_pop_clr) | w_push_set;
            if (w_accept) begin
                r_sel    <= w_sel;
                r_int_pc <= VEC_BASE + (32'(w_sel) * VEC_STRIDE);
            end else if (w_pop) begin
                r_int_pc <= r_stk_epc[w_top];
            end
            if (w_push) begin
                r_depth <= r_depth + 1'b1;
            end else if (w_pop) begin
                r_depth <= r_depth - 1'b1;
            end
            if (w_err) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    // epc_in is captured on the unstalled exit cycle of S_ENT.
    always_ff @(posedge clk) begin
        if (!RST && w_push) begin
            r_stk_epc[r_depth] <= epc_in;
            r_stk_src[r_depth] <= r_sel;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (RST)
        (r_state == S_ENT && !stall) |-> (r_depth < c_DW'(NUM_SRC)));

    assign interrupt  = (r_state == S_ENT);
    assign eret       = (r_state == S_RET);
    assign int_pc     = r_int_pc;
    assign in_service = r_in_service;
    assign depth      = r_depth;
    assign stack_err  = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_int_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_int_seq_ctrl : directed scenarios plus randomized run against a queue model
// Rev 1.0
// ============================================================================
module tb_int_seq_ctrl;

    localparam int NUM_SRC = 3;

    logic               clk = 1'b0;
    logic               RST;
    logic [NUM_SRC-1:0] irq_req;
    logic               int_en;
    logic               stall;
    logic               eret_req;
    logic [31:0]        epc_in;
    logic               interrupt;
    logic               eret;
    logic [31:0]        int_pc;
    logic [NUM_SRC-1:0] in_service;
    logic [1:0]         depth;
    logic               stack_err;

    int checks = 0;
    int errors = 0;

    int_seq_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .VEC_BASE   (32'h0000_0200),
        .VEC_STRIDE (32'h0000_0010)
    ) u_dut (
        .clk        (clk),
        .RST        (RST),
        .irq_req    (irq_req),
        .int_en     (int_en),
        .stall      (stall),
        .eret_req   (eret_req),
        .epc_in     (epc_in),
        .interrupt  (interrupt),
        .eret       (eret),
        .int_pc     (int_pc),
        .in_service (in_service),
        .depth      (depth),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    // Reference model: stack of saved contexts, pending set, current pulse.
    typedef struct {
        logic [31:0] epc;
        int          src;
    } ent_t;

    ent_t               stk[$];
    logic [NUM_SRC-1:0] m_pending;
    logic [NUM_SRC-1:0] m_prev;
    int                 m_kind;   // 0 none, 1 vector pulse, 2 return pulse
    int                 m_src;
    logic [31:0]        m_pc;
    logic               m_err;

    function automatic logic [NUM_SRC-1:0] m_ins();
        logic [NUM_SRC-1:0] v;
        v = '0;
        foreach (stk[k]) v[stk[k].src] = 1'b1;
        return v;
    endfunction

    function automatic bit outranks_stack(int i);
        foreach (stk[k]) if (stk[k].src <= i) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_tick();
        logic [NUM_SRC-1:0] nset;
        logic [NUM_SRC-1:0] clr;
        ent_t               e;
`ifdef INTC_IRQ_EDGE_EN
        nset = irq_req & ~m_prev;
`else
        nset = irq_req;
`endif
        clr = '0;
        if (RST) begin
            stk.delete();
            m_pending = '0;
            m_prev    = '0;
            m_kind    = 0;
            m_src     = 0;
            m_pc      = 32'h0;
            m_err     = 1'b0;
            return;
        end
        if (m_kind == 1) begin
            if (!stall) begin
                stk.push_back('{epc_in, m_src});
                m_kind = 0;
            end
        end else if (m_kind == 2) begin
            if (!stall) m_kind = 0;
        end else if (!stall) begin
            if (eret_req) begin
                if (stk.size() > 0) begin
                    e      = stk.pop_back();
                    m_pc   = e.epc;
                    m_kind = 2;
                end else begin
                    m_err = 1'b1;
                end
            end else if (int_en) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (m_kind == 0 && m_pending[i] && outranks_stack(i)) begin
                        m_kind = 1;
                        m_src  = i;
                        m_pc   = 32'h200 + 32'(i) * 32'h10;
                        clr[i] = 1'b1;
                    end
                end
            end
        end
        m_pending = (m_pending & ~clr) | nset;
        m_prev    = irq_req;
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_tick();
            @(negedge clk);
        end
    endtask

    function automatic logic [39:0] obs();
        return {interrupt, eret, int_pc, in_service, depth, stack_err};
    endfunction

    function automatic logic [39:0] ev(bit i, bit r, logic [31:0] pc,
                                       logic [2:0] ins, logic [1:0] d, bit err);
        return {i, r, pc, ins, d, err};
    endfunction

    logic [39:0] e;

    task automatic test_reset();
        RST = 1'b1; irq_req = '0; int_en = 1'b1; stall = 1'b0;
        eret_req = 1'b0; epc_in = 32'h40;
        step(2);
        RST = 1'b0;
        e = ev(0, 0, 32'h0, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL reset got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_single();
        epc_in = 32'h40; irq_req = 3'b010; step(); irq_req = '0;
        e = ev(0, 0, 32'h0, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL single_decide got=%h exp=%h", obs(), e); end
        step();
        e = ev(1, 0, 32'h210, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL single_int got=%h exp=%h", obs(), e); end
        step();
        e = ev(0, 0, 32'h210, 3'b010, 2'd1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL single_push got=%h exp=%h", obs(), e); end
        eret_req = 1'b1; step(); eret_req = 1'b0;
        e = ev(0, 1, 32'h40, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL single_eret got=%h exp=%h", obs(), e); end
        step();
        e = ev(0, 0, 32'h40, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL single_quiet got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_nested();
        epc_in = 32'h40; irq_req = 3'b100; step(); irq_req = '0; step();
        e = ev(1, 0, 32'h220, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL nest_int2 got=%h exp=%h", obs(), e); end
        step();
        epc_in = 32'h224; irq_req = 3'b001; step(); irq_req = '0; step();
        e = ev(1, 0, 32'h200, 3'b100, 2'd1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL nest_int0 got=%h exp=%h", obs(), e); end
        step();
        e = ev(0, 0, 32'h200, 3'b101, 2'd2, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL nest_depth2 got=%h exp=%h", obs(), e); end
        eret_req = 1'b1; step(); eret_req = 1'b0;
        e = ev(0, 1, 32'h224, 3'b100, 2'd1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL nest_eret1 got=%h exp=%h", obs(), e); end
        step();
        eret_req = 1'b1; step(); eret_req = 1'b0;
        e = ev(0, 1, 32'h40, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL nest_eret2 got=%h exp=%h", obs(), e); end
        step();
    endtask

    task automatic test_no_preempt();
        epc_in = 32'h80; irq_req = 3'b010; step(); irq_req = '0; step(2);
        irq_req = 3'b100; step(); irq_req = '0;
        for (int k = 0; k < 3; k++) begin
            e = ev(0, 0, 32'h210, 3'b010, 2'd1, 0);
            checks++; if (obs() !== e) begin errors++; $display("FAIL nopre_blocked%0d got=%h exp=%h", k, obs(), e); end
            step();
        end
        eret_req = 1'b1; step(); eret_req = 1'b0;
        e = ev(0, 1, 32'h80, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL nopre_eret got=%h exp=%h", obs(), e); end
        step(2);
        e = ev(1, 0, 32'h220, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL nopre_int2 got=%h exp=%h", obs(), e); end
        step();
        eret_req = 1'b1; step(); eret_req = 1'b0; step();
    endtask

    task automatic test_eret_vs_irq();
        epc_in = 32'h300; irq_req = 3'b010; step(); irq_req = '0; step(2);
        eret_req = 1'b1; irq_req = 3'b001; step(); eret_req = 1'b0; irq_req = '0;
        e = ev(0, 1, 32'h300, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL race_eret got=%h exp=%h", obs(), e); end
        step();
        e = ev(0, 0, 32'h300, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL race_gap got=%h exp=%h", obs(), e); end
        step();
        e = ev(1, 0, 32'h200, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL race_int0 got=%h exp=%h", obs(), e); end
        step();
        eret_req = 1'b1; step(); eret_req = 1'b0; step();
    endtask

    task automatic test_stall_ent();
        epc_in = 32'h500; irq_req = 3'b001; step(); irq_req = '0; step();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) stall = 1'b0;
            e = ev(1, 0, 32'h200, 3'b000, 2'd0, 0);
            checks++; if (obs() !== e) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", k, obs(), e); end
            if (k < 3) step();
        end
        epc_in = 32'h504; step();
        e = ev(0, 0, 32'h200, 3'b001, 2'd1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL stall_push got=%h exp=%h", obs(), e); end
        eret_req = 1'b1; step(); eret_req = 1'b0;
        e = ev(0, 1, 32'h504, 3'b000, 2'd0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL stall_epc got=%h exp=%h", obs(), e); end
        step();
    endtask

    task automatic test_stack_err();
        eret_req = 1'b1; step(); eret_req = 1'b0;
        e = ev(0, 0, 32'h504, 3'b000, 2'd0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL err_set got=%h exp=%h", obs(), e); end
        step(2);
        checks++; if (obs() !== e) begin errors++; $display("FAIL err_sticky got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_reset_ent();
        irq_req = 3'b010; step(); irq_req = '0; step();
        e = ev(1, 0, 32'h210, 3'b000, 2'd0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rst_pre got=%h exp=%h", obs(), e); end
        RST = 1'b1; step(); RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = ev(0, 0, 32'h0, 3'b000, 2'd0, 0);
            checks++; if (obs() !== e) begin errors++; $display("FAIL rst_abort%0d got=%h exp=%h", k, obs(), e); end
            step();
        end
    endtask

    task automatic test_random();
        RST = 1'b1; step(); RST = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NUM_SRC; b++) irq_req[b] = ($urandom_range(0, 7) == 0);
            int_en   = ($urandom_range(0, 9) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            eret_req = ($urandom_range(0, 5) == 0);
            epc_in   = {$urandom_range(0, 32'hFFFF), 2'b00};
            step();
            e = {m_kind == 1, m_kind == 2, m_pc, m_ins(), 2'(stk.size()), m_err};
            checks++; if (obs() !== e) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", n, obs(), e); end
        end
        irq_req = '0; stall = 1'b0; eret_req = 1'b0; int_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_nested();
        test_no_preempt();
        test_eret_vs_irq();
        test_stall_ent();
        test_stack_err();
        test_reset_ent();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
